// File: rtl/mem_access_unit.sv
// Load/store access unit: validates one load or store request, runs a single
// handshake on a 32-bit word bus with a bounded wait, extracts and extends
// load data, and reports completion with an error flag.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_mem_wren,
  input  logic [2:0]  i_ld_sel,
  input  logic [1:0]  i_st_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Access width codes after decoding the selects.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  // Last wait-count value at which a missing ack aborts the access.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [2:0]  r_ld_sel;
  logic [1:0]  r_lane;
  logic        r_is_load;

  size_t       w_size;
  logic        w_bad;
  logic        w_err_nxt;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  // Decode the incoming request: width, legality, byte enables, store lanes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_size  = SZ_NONE;
    w_be    = 4'b0000;
    w_wdata = i_st_data;
    if (i_mem_wren) begin
      case (i_st_sel)
        2'd0:    w_size = SZ_BYTE;
        2'd1:    w_size = SZ_HALF;
        2'd2:    w_size = SZ_WORD;
        default: w_size = SZ_NONE;
      endcase
    end else begin
      case (i_ld_sel)
        3'd0, 3'd3: w_size = SZ_BYTE;
        3'd1, 3'd4: w_size = SZ_HALF;
        3'd2:       w_size = SZ_WORD;
        default:    w_size = SZ_NONE;
      endcase
    end
    w_bad = (w_size == SZ_NONE) ||
            ((w_size == SZ_HALF) && i_addr[0]) ||
            ((w_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    case (w_size)
      SZ_BYTE: w_be = 4'b0001 << i_addr[1:0];
      SZ_HALF: w_be = i_addr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    case (i_st_sel)
      2'd0:    w_wdata = {4{i_st_data[7:0]}};
      2'd1:    w_wdata = {2{i_st_data[15:0]}};
      default: w_wdata = i_st_data;
    endcase
  end

  // Next-state logic and the error flag that accompanies completion.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_state_nxt = w_bad ? S_DONE : S_BUS;
          w_err_nxt   = w_bad;
        end
      end
      S_BUS: begin
        if (i_bus_ack) begin
          w_state_nxt = S_DONE;
        end else if (r_wait_cnt == WAIT_LIMIT) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    case (r_lane)
      2'd0:    w_ld_byte = i_bus_rdata[7:0];
      2'd1:    w_ld_byte = i_bus_rdata[15:8];
      2'd2:    w_ld_byte = i_bus_rdata[23:16];
      default: w_ld_byte = i_bus_rdata[31:24];
    endcase
    w_ld_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (r_ld_sel)
      3'd0:    w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'd1:    w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'd3:    w_ld_ext = {24'd0, w_ld_byte};
      3'd4:    w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = i_bus_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter and the request fields the load path needs after IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wait_cnt <= 8'd0;
      r_ld_sel   <= 3'd0;
      r_lane     <= 2'd0;
      r_is_load  <= 1'b0;
    end else if (r_state == S_IDLE && w_state_nxt == S_BUS) begin
      r_wait_cnt <= 8'd0;
      r_ld_sel   <= i_ld_sel;
      r_lane     <= i_addr[1:0];
      r_is_load  <= ~i_mem_wren;
    end else if (r_state == S_BUS && !i_bus_ack) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Registered outputs, all derived from the upcoming state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_ld_data   <= 32'd0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'd0;
      o_bus_wdata <= 32'd0;
      o_bus_be    <= 4'b0000;
    end else begin
      o_busy    <= (w_state_nxt != S_IDLE);
      o_done    <= (w_state_nxt == S_DONE);
      o_err     <= w_err_nxt;
      o_bus_req <= (w_state_nxt == S_BUS);
      if (r_state == S_IDLE && w_state_nxt == S_BUS) begin
        o_bus_we    <= i_mem_wren;
        o_bus_addr  <= {i_addr[31:2], 2'b00};
        o_bus_wdata <= w_wdata;
        o_bus_be    <= w_be;
      end else if (w_state_nxt != S_BUS) begin
        o_bus_we    <= 1'b0;
        o_bus_addr  <= 32'd0;
        o_bus_wdata <= 32'd0;
        o_bus_be    <= 4'b0000;
      end
      if (r_state == S_BUS && i_bus_ack && r_is_load) begin
        o_ld_data <= w_ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of timing, lanes and
// extension, checked every cycle, plus directed cases with literal results.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic        i_mem_wren;
  logic [2:0]  i_ld_sel;
  logic [1:0]  i_st_sel;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  mem_access_unit #(.TIMEOUT(T)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_mem_wren  (i_mem_wren),
    .i_ld_sel    (i_ld_sel),
    .i_st_sel    (i_st_sel),
    .i_addr      (i_addr),
    .i_st_data   (i_st_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_ld_data   (o_ld_data),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_be    (o_bus_be),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, set just after each rising edge.
  logic        cmp_en = 1'b0;
  logic        exp_busy, exp_done, exp_err, exp_bus_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;
  logic [31:0] m_ld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model, on the falling edge.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("busy", 32'(o_busy), 32'(exp_busy));
      check("done", 32'(o_done), 32'(exp_done));
      check("bus_req", 32'(o_bus_req), 32'(exp_bus_req));
      check("ld_data", o_ld_data, exp_ld);
      if (exp_done) check("err", 32'(o_err), 32'(exp_err));
      if (exp_bus_req) begin
        check("bus_addr", o_bus_addr, exp_addr);
        check("bus_we", 32'(o_bus_we), 32'(exp_we));
        check("bus_be", 32'(o_bus_be), 32'(exp_be));
        if (exp_we) check("bus_wdata", o_bus_wdata, exp_wdata);
      end
    end
  end

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_bus_req = 1'b0;
    exp_ld = m_ld;
  endtask

  task automatic scramble_inputs();
    i_req       = 1'($urandom_range(0, 1));
    i_mem_wren  = 1'($urandom_range(0, 1));
    i_ld_sel    = 3'($urandom_range(0, 7));
    i_st_sel    = 2'($urandom_range(0, 3));
    i_addr      = $urandom;
    i_st_data   = $urandom;
    i_bus_ack   = 1'($urandom_range(0, 1));
    i_bus_rdata = $urandom;
  endtask

  // One request. Entered and left just after a rising edge in an idle cycle.
  // ack_at: BUS cycle (1-based) in which the responder acks; 0 = never.
  task automatic run_txn(input logic wren, input logic [2:0] ld, input logic [1:0] st,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int ack_at,
                         output int obs_bus, output int obs_done_k, output int obs_done_cnt,
                         output logic obs_err, output logic [31:0] obs_wdata,
                         output logic [3:0] obs_be, output logic obs_we);
    int size, off, n, kd;
    bit sgn, valid, bad, acked;
    logic [3:0]  be;
    logic [31:0] wd, ext;
    longint v;
    off = int'(addr % 4);
    if (wren) begin
      valid = (st != 2'd3);
      size  = (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
      sgn   = 1'b0;
    end else begin
      valid = (ld <= 3'd4);
      size  = (ld == 3'd0 || ld == 3'd3) ? 1 : (ld == 3'd1 || ld == 3'd4) ? 2 : 4;
      sgn   = (ld <= 3'd1);
    end
    bad = !valid || (off % size != 0);
    be  = 4'(((1 << size) - 1) << off);
    for (int b = 0; b < 4; b++) wd[b*8 +: 8] = data[(b % size)*8 +: 8];
    v = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
    ext   = v[31:0];
    acked = (ack_at >= 1) && (ack_at <= T - 1);
    n     = acked ? ack_at : T - 1;
    kd    = bad ? 1 : n + 1;

    obs_bus = 0; obs_done_k = 0; obs_done_cnt = 0; obs_err = 1'b0;
    obs_wdata = 32'd0; obs_be = 4'd0; obs_we = 1'b0;

    set_idle_exp();
    scramble_inputs();
    i_req = 1'b1; i_mem_wren = wren; i_ld_sel = ld; i_st_sel = st;
    i_addr = addr; i_st_data = data;

    for (int k = 1; k <= kd; k++) begin
      @(posedge i_clk); #1;
      exp_busy    = 1'b1;
      exp_done    = (k == kd);
      exp_bus_req = !bad && (k <= n);
      exp_err     = bad || !acked;
      exp_addr    = {addr[31:2], 2'b00};
      exp_we      = wren;
      exp_be      = be;
      exp_wdata   = wd;
      if (k == kd && !bad && acked && !wren) m_ld = ext;
      exp_ld = m_ld;
      if (o_bus_req) begin
        if (obs_bus == 0) begin
          obs_wdata = o_bus_wdata; obs_be = o_bus_be; obs_we = o_bus_we;
        end
        obs_bus++;
      end
      if (o_done) begin
        if (obs_done_cnt == 0) begin
          obs_done_k = k; obs_err = o_err;
        end
        obs_done_cnt++;
      end
      scramble_inputs();
      if (!bad && k <= n) begin
        i_bus_ack   = (k == ack_at);
        i_bus_rdata = (k == ack_at) ? rdata : $urandom;
      end
    end
    @(posedge i_clk); #1;
    set_idle_exp();
    if (o_done) obs_done_cnt++;
    i_req = 1'b0; i_bus_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      i_req = 1'b0;
      i_bus_ack = 1'($urandom_range(0, 1));
      i_bus_rdata = $urandom;
      @(posedge i_clk); #1;
      set_idle_exp();
    end
    i_bus_ack = 1'b0;
  endtask

  int ob, odk, odc;
  logic oe, owe;
  logic [31:0] owd;
  logic [3:0] obe;

  initial begin
    i_reset = 1'b0; i_req = 1'b0; i_mem_wren = 1'b0; i_ld_sel = 3'd0; i_st_sel = 2'd0;
    i_addr = 32'd0; i_st_data = 32'd0; i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
    m_ld = 32'd0;
    set_idle_exp();
    @(posedge i_clk); #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_bus_req", 32'(o_bus_req), 32'd0);
    check("rst_ld_data", o_ld_data, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    cmp_en = 1'b1;

    // LB at 0x103, zero-wait ack: accepted on the first edge after reset.
    run_txn(1'b0, 3'd0, 2'd3, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1,
            ob, odk, odc, oe, owd, obe, owe);
    check("lb_done_k", 32'(odk), 32'd2);
    check("lb_be", 32'(obe), 32'b1000);
    check("lb_ld", o_ld_data, 32'hFFFF_FF80);
    check("lb_bus_cycles", 32'(ob), 32'd1);

    // SH at 0x202, ack in the third BUS cycle.
    run_txn(1'b1, 3'd7, 2'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3,
            ob, odk, odc, oe, owd, obe, owe);
    check("sh_wdata", owd, 32'hABCD_ABCD);
    check("sh_be", 32'(obe), 32'b1100);
    check("sh_we", 32'(owe), 32'd1);
    check("sh_done_cnt", 32'(odc), 32'd1);
    check("sh_err", 32'(oe), 32'd0);
    check("sh_ld_kept", o_ld_data, 32'hFFFF_FF80);

    // Misaligned LW: immediate error, no bus activity, load data kept.
    run_txn(1'b0, 3'd2, 2'd0, 32'h0000_0101, 32'h0, 32'h5555_5555, 1,
            ob, odk, odc, oe, owd, obe, owe);
    check("lw_mis_done_k", 32'(odk), 32'd1);
    check("lw_mis_err", 32'(oe), 32'd1);
    check("lw_mis_bus", 32'(ob), 32'd0);
    check("lw_mis_ld_kept", o_ld_data, 32'hFFFF_FF80);

    // LHU at 0x102.
    run_txn(1'b0, 3'd4, 2'd0, 32'h0000_0102, 32'h0, 32'h8001_0000, 1,
            ob, odk, odc, oe, owd, obe, owe);
    check("lhu_ld", o_ld_data, 32'h0000_8001);

    // Timeout with no ack, then ack exactly at the limit.
    run_txn(1'b0, 3'd2, 2'd0, 32'h0000_0300, 32'h0, 32'h0, 0,
            ob, odk, odc, oe, owd, obe, owe);
    check("to_bus_cycles", 32'(ob), 32'd3);
    check("to_err", 32'(oe), 32'd1);
    check("to_ld_kept", o_ld_data, 32'h0000_8001);
    run_txn(1'b0, 3'd2, 2'd0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 3,
            ob, odk, odc, oe, owd, obe, owe);
    check("lim_bus_cycles", 32'(ob), 32'd3);
    check("lim_err", 32'(oe), 32'd0);
    check("lim_ld", o_ld_data, 32'hCAFE_F00D);

    // Reset asserted in the middle of BUS.
    cmp_en = 1'b0;
    i_req = 1'b1; i_mem_wren = 1'b0; i_ld_sel = 3'd2; i_addr = 32'h0000_0400;
    i_bus_ack = 1'b0;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    check("mid_bus_req", 32'(o_bus_req), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    check("mid_rst_bus_req", 32'(o_bus_req), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_addr", o_bus_addr, 32'd0);
    check("mid_rst_be", 32'(o_bus_be), 32'd0);
    check("mid_rst_ld", o_ld_data, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    i_bus_ack = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    i_bus_ack = 1'b0;
    check("late_ack_busy", 32'(o_busy), 32'd0);
    check("late_ack_done", 32'(o_done), 32'd0);
    check("late_ack_ld", o_ld_data, 32'd0);
    m_ld = 32'd0;
    set_idle_exp();
    cmp_en = 1'b1;
    run_txn(1'b0, 3'd2, 2'd0, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 2,
            ob, odk, odc, oe, owd, obe, owe);
    check("post_rst_err", 32'(oe), 32'd0);
    check("post_rst_done_cnt", 32'(odc), 32'd1);
    check("post_rst_ld", o_ld_data, 32'h0BAD_CAFE);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, int'($urandom_range(0, 4)),
              ob, odk, odc, oe, owd, obe, owe);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
